// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types, default sizes and sizing helpers for the serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 8;

    // number of CHUNK-wide slices in a WIDTH-wide operand
    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // counter width for slice index 0..N-1, never narrower than one bit
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_64_sub_chunk.sv
// sub_chunk: combinational CHUNK-bit ripple-borrow subtract slice, d = a - b - bin
module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    // the extra top bit of the widened difference is the borrow out of the slice
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};

endmodule

// File: rtl/serial_subtractor_64.sv
// serial_subtractor_64: multi-cycle in1 - in2 - bin, CHUNK bits per clock; SUB_SIGNED_OVF_EN adds ovf
module serial_subtractor_64
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int CW = cnt_width(WIDTH, CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("serial_subtractor_64: WIDTH must be a multiple of CHUNK");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             last;
    logic             accept;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_d;
    logic             slice_bout;

    assign accept  = (state == IDLE) && in_valid;
    assign last    = (cnt == CW'(N - 1));
    assign slice_a = a[int'(cnt) * CHUNK +: CHUNK];
    assign slice_b = b[int'(cnt) * CHUNK +: CHUNK];

    sub_chunk #(.CHUNK(CHUNK)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (borrow),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // next state: accept in IDLE, run N slices, hold result until the consumer takes it
    always_comb begin
        state_next = state;
        if (state == IDLE)      state_next = in_valid ? BUSY : IDLE;
        else if (state == BUSY) state_next = last ? DONE : BUSY;
        else if (state == DONE) state_next = out_ready ? IDLE : DONE;
        else                    state_next = IDLE;
    end

    // handshake outputs are pure functions of the state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // operand capture and one slice per BUSY cycle; the counter holds at N-1 instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            a      <= in1;
            b      <= in2;
            cnt    <= '0;
            borrow <= bin;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (state == BUSY) begin
            diff[int'(cnt) * CHUNK +: CHUNK] <= slice_d;
            borrow <= slice_bout;
            cnt    <= last ? cnt : cnt + CW'(1);
            if (last) bout <= slice_bout;
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    // signed overflow latched alongside bout: operand signs differ and the result sign left the minuend's
    always_ff @(posedge clk) begin
        if (rst || accept)
            ovf <= 1'b0;
        else if (state == BUSY && last)
            ovf <= (a[WIDTH-1] != b[WIDTH-1]) && (slice_d[CHUNK-1] != a[WIDTH-1]);
    end
`endif

endmodule
